// File: rtl/weight_load_arbiter_if.sv
// Request/grant/data bundle between weight_load_arbiter, the weight caches and the SRAM read port.
// master = arbiter side, slave = caches + SRAM side.
interface weight_load_arbiter_if #(
    parameter int REQ_NUM = 4,
    parameter int ADDR_W  = 19,
    parameter int CNT_W   = 11,
    parameter int DATA_W  = 128
);
    logic [REQ_NUM-1:0]        ldr_req;
    logic [REQ_NUM-1:0]        ldr_grant;
    logic [REQ_NUM*ADDR_W-1:0] ldr_base_addr;
    logic [REQ_NUM*CNT_W-1:0]  ldr_count;
    logic [REQ_NUM-1:0]        ldr_valid;
    logic [DATA_W-1:0]         ldr_data;
    logic [REQ_NUM-1:0]        ldr_done_sig;
    logic                      mem_rd_en;
    logic [ADDR_W-1:0]         mem_rd_addr;
    logic [DATA_W-1:0]         mem_rd_data;
    logic                      busy;

    // Handshake: a requester holds ldr_req until it sees its one-cycle ldr_grant pulse;
    // ldr_valid[owner] qualifies ldr_data for exactly one beat, ldr_done_sig[owner] ends the burst.
    modport master (
        input  ldr_req, ldr_base_addr, ldr_count, mem_rd_data,
        output ldr_grant, ldr_valid, ldr_data, ldr_done_sig, mem_rd_en, mem_rd_addr, busy
    );
    modport slave (
        output ldr_req, ldr_base_addr, ldr_count, mem_rd_data,
        input  ldr_grant, ldr_valid, ldr_data, ldr_done_sig, mem_rd_en, mem_rd_addr, busy
    );
endinterface

// File: rtl/weight_load_arbiter.sv
// Shared weight loader: arbitrates cache requests, bursts words out of weight SRAM, streams them back.
// Define WEIGHT_LOAD_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module weight_load_arbiter #(
    parameter int REQ_NUM = 4,
    parameter int ADDR_W  = 19,
    parameter int CNT_W   = 11,
    parameter int DATA_W  = 128,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    weight_load_arbiter_if.master bus,
    output logic [2:0]           state_o
);
    localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, ISSUE, DRAIN, DONE} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     owner_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [REQ_NUM-1:0]   grant_q;
    logic [REQ_NUM-1:0]   valid_q;
    logic [REQ_NUM-1:0]   done_q;
    logic [DATA_W-1:0]    data_q;
    logic                 rd_en_q;
    logic                 busy_q;
    logic [MEM_LAT-1:0]   pipe_q;
`ifndef WEIGHT_LOAD_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]     rr_q;
`endif

    logic [IDX_W-1:0]     win_d;
    logic [REQ_NUM-1:0]   win_oh_d;
    logic                 found_d;
    logic [REQ_NUM-1:0]   owner_oh;

    always_comb begin
        win_d    = '0;
        win_oh_d = '0;
        found_d  = 1'b0;
`ifdef WEIGHT_LOAD_ARB_FIXED_PRIO_EN
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (bus.ldr_req[k]) begin
                win_d   = IDX_W'(k);
                found_d = 1'b1;
            end
        end
`else
        for (int k = 0; k < REQ_NUM; k++) begin
            if (!found_d && bus.ldr_req[(int'(rr_q) + k) % REQ_NUM]) begin
                win_d   = IDX_W'((int'(rr_q) + k) % REQ_NUM);
                found_d = 1'b1;
            end
        end
`endif
        if (found_d) win_oh_d[win_d] = 1'b1;
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            data_q  <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            pipe_q  <= '0;
`ifndef WEIGHT_LOAD_ARB_FIXED_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            // pipe_q[MEM_LAT-1] is high in the cycle the SRAM word for an issued read is on mem_rd_data
            pipe_q[0] <= rd_en_q;
            for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            if (pipe_q[MEM_LAT-1]) begin
                valid_q <= owner_oh;
                data_q  <= bus.mem_rd_data;
            end else begin
                valid_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        owner_q <= win_d;
                        addr_q  <= bus.ldr_base_addr[win_d*ADDR_W +: ADDR_W];
                        cnt_q   <= bus.ldr_count[win_d*CNT_W +: CNT_W];
                        grant_q <= win_oh_d;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
`ifndef WEIGHT_LOAD_ARB_FIXED_PRIO_EN
                    rr_q <= (owner_q == IDX_W'(REQ_NUM - 1)) ? '0 : owner_q + 1'b1;
`endif
                    if (cnt_q == '0) begin
                        done_q  <= owner_oh;
                        state_q <= DONE;
                    end else begin
                        rd_en_q <= 1'b1;
                        cnt_q   <= cnt_q - 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // cnt_q counts reads still to issue after the current one
                    if (cnt_q == '0) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                    end
                end
                DRAIN: begin
                    if (pipe_q == '0 && valid_q != '0) begin
                        done_q  <= owner_oh;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ldr_grant    = grant_q;
    assign bus.ldr_valid    = valid_q;
    assign bus.ldr_data     = data_q;
    assign bus.ldr_done_sig = done_q;
    assign bus.mem_rd_en    = rd_en_q;
    assign bus.mem_rd_addr  = addr_q;
    assign bus.busy         = busy_q;
    assign state_o          = state_q;
endmodule
